// File: rtl/int_res_mem_arbiter_pkg.sv
// Shared sizing, types and FSM encodings for the int-res memory arbiter.
// Imported by the address decoder and the arbiter top.
package int_res_mem_arbiter_pkg;

  localparam int unsigned CIM_INT_RES_NUM_BANKS          = 4;
  localparam int unsigned CIM_INT_RES_BANK_SIZE_NUM_WORD = 14336;

  localparam int unsigned NUM_BANKS        = CIM_INT_RES_NUM_BANKS;
  localparam int unsigned BANK_WORDS       = CIM_INT_RES_BANK_SIZE_NUM_WORD;
  localparam int unsigned INT_RES_MAX_ADDR = NUM_BANKS * BANK_WORDS;

  localparam int unsigned INT_RES_ADDR_W      = 16;
  localparam int unsigned INT_RES_BANK_ADDR_W = 14;

  typedef logic [INT_RES_ADDR_W-1:0]      IntResAddr_t;
  typedef logic [INT_RES_BANK_ADDR_W-1:0] IntResBankAddr_t;
  typedef logic [7:0]                     IntResSingle_t;
  typedef logic [15:0]                    IntResDouble_t;

  typedef enum logic {SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1} DataWidth_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS_1, ARB_ACCESS_2} IntResArbState_t;

  typedef enum logic {REQ_COMPUTE, REQ_EEG} IntResRequester_t;

  function automatic IntResDouble_t sext_single(input IntResSingle_t b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/int_res_addr_decode.sv
// Combinational flat-address to bank decode for the int-res memory.
// Takes a 17b address so that the carry out of addr+1 lands out of range.
module int_res_addr_decode
  import int_res_mem_arbiter_pkg::*;
(
  input  logic [INT_RES_ADDR_W:0] addr,
  output logic [NUM_BANKS-1:0]    bank_oh,
  output IntResBankAddr_t         bank_addr,
  output logic                    out_of_range
);

  always_comb begin
    bank_oh      = '0;
    bank_addr    = '0;
    out_of_range = 1'b1;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (32'(addr) >= i * BANK_WORDS && 32'(addr) < (i + 1) * BANK_WORDS) begin
        bank_oh[i]   = 1'b1;
        bank_addr    = IntResBankAddr_t'(32'(addr) - i * BANK_WORDS);
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/int_res_mem_arbiter.sv
// Round-robin arbiter sharing the banked int-res memory between compute (A) and EEG load (B).
// Define INT_RES_ARB_STATS_EN to add saturating grant/stall statistics counters.
module int_res_mem_arbiter
  import int_res_mem_arbiter_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_a_valid,
  output logic                        req_a_ready,
  input  logic                        req_a_wen,
  input  IntResAddr_t                 req_a_addr,
  input  DataWidth_t                  req_a_width,
  input  IntResDouble_t               req_a_wdata,
  input  logic                        req_b_valid,
  output logic                        req_b_ready,
  input  logic                        req_b_wen,
  input  IntResAddr_t                 req_b_addr,
  input  DataWidth_t                  req_b_width,
  input  IntResDouble_t               req_b_wdata,
  output logic                        rsp_a_valid,
  output IntResDouble_t               rsp_a_rdata,
  output logic                        rsp_b_valid,
  output IntResDouble_t               rsp_b_rdata,
  output logic [NUM_BANKS-1:0]        bank_en,
  output logic                        bank_wen,
  output IntResBankAddr_t             bank_addr,
  output IntResSingle_t               bank_wdata,
  input  logic [NUM_BANKS-1:0][7:0]   bank_rdata,
`ifdef INT_RES_ARB_STATS_EN
  output logic [31:0]                 stat_grants_a,
  output logic [31:0]                 stat_grants_b,
  output logic [31:0]                 stat_stall_cycles,
`endif
  output logic                        addr_err
);

  IntResArbState_t  state_q;
  IntResRequester_t rr_q;
  IntResRequester_t owner_q;
  logic             wen_q;
  IntResAddr_t      addr_q;
  DataWidth_t       width_q;
  IntResSingle_t    wdata_hi_q;
  IntResSingle_t    lo_q;
  logic [NUM_BANKS-1:0] rd_sel_q;
  logic             rsp_double_q;

  logic             grant_a, grant_b, hs, last_access;
  logic             sel_wen;
  IntResAddr_t      sel_addr;
  DataWidth_t       sel_width;
  IntResDouble_t    sel_wdata;
  logic [NUM_BANKS-1:0] lo_oh, hi_oh;
  IntResBankAddr_t  lo_baddr, hi_baddr;
  logic             lo_oor, hi_oor;
  IntResSingle_t    rd_byte;
  IntResDouble_t    rsp_rdata;

  // rr_q names the side that wins a tie next.
  always_comb begin
    grant_a = (state_q == ARB_IDLE) && req_a_valid && (!req_b_valid || rr_q == REQ_COMPUTE);
    grant_b = (state_q == ARB_IDLE) && req_b_valid && (!req_a_valid || rr_q == REQ_EEG);
  end

  assign hs          = grant_a | grant_b;
  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;

  assign sel_wen   = grant_b ? req_b_wen   : req_a_wen;
  assign sel_addr  = grant_b ? req_b_addr  : req_a_addr;
  assign sel_width = grant_b ? req_b_width : req_a_width;
  assign sel_wdata = grant_b ? req_b_wdata : req_a_wdata;

  assign last_access = (state_q == ARB_ACCESS_2) ||
                       (state_q == ARB_ACCESS_1 && width_q == SINGLE_WIDTH);

  int_res_addr_decode u_decode_lo (
    .addr         ({1'b0, sel_addr}),
    .bank_oh      (lo_oh),
    .bank_addr    (lo_baddr),
    .out_of_range (lo_oor)
  );

  int_res_addr_decode u_decode_hi (
    .addr         ({1'b0, addr_q} + 17'd1),
    .bank_oh      (hi_oh),
    .bank_addr    (hi_baddr),
    .out_of_range (hi_oor)
  );

  // Bank data arrives the cycle after its enable; rd_sel_q remembers which bank that was.
  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (rd_sel_q[i]) rd_byte |= bank_rdata[i];
    end
  end

  assign rsp_rdata   = rsp_double_q ? {rd_byte, lo_q} : sext_single(rd_byte);
  assign rsp_a_rdata = rsp_a_valid ? rsp_rdata : '0;
  assign rsp_b_rdata = rsp_b_valid ? rsp_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      rr_q         <= REQ_COMPUTE;
      owner_q      <= REQ_COMPUTE;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      width_q      <= SINGLE_WIDTH;
      wdata_hi_q   <= '0;
      lo_q         <= '0;
      rd_sel_q     <= '0;
      rsp_double_q <= 1'b0;
      rsp_a_valid  <= 1'b0;
      rsp_b_valid  <= 1'b0;
      bank_en      <= '0;
      bank_wen     <= 1'b0;
      bank_addr    <= '0;
      bank_wdata   <= '0;
      addr_err     <= 1'b0;
    end else begin
      rsp_a_valid <= 1'b0;
      rsp_b_valid <= 1'b0;
      rd_sel_q    <= bank_wen ? '0 : bank_en;

      unique case (state_q)
        ARB_IDLE: begin
          if (hs) begin
            owner_q    <= grant_b ? REQ_EEG : REQ_COMPUTE;
            rr_q       <= grant_b ? REQ_COMPUTE : REQ_EEG;
            wen_q      <= sel_wen;
            addr_q     <= sel_addr;
            width_q    <= sel_width;
            wdata_hi_q <= sel_wdata[15:8];
            bank_en    <= lo_oh;
            bank_wen   <= sel_wen & ~lo_oor;
            bank_addr  <= lo_baddr;
            bank_wdata <= sel_wen ? sel_wdata[7:0] : '0;
            if (lo_oor) addr_err <= 1'b1;
            state_q    <= ARB_ACCESS_1;
          end
        end
        ARB_ACCESS_1: begin
          if (width_q == DOUBLE_WIDTH) begin
            bank_en    <= hi_oh;
            bank_wen   <= wen_q & ~hi_oor;
            bank_addr  <= hi_baddr;
            bank_wdata <= wen_q ? wdata_hi_q : '0;
            if (hi_oor) addr_err <= 1'b1;
            state_q    <= ARB_ACCESS_2;
          end
        end
        ARB_ACCESS_2: begin
          lo_q <= rd_byte;
        end
        default: state_q <= ARB_IDLE;
      endcase

      if (last_access) begin
        bank_en      <= '0;
        bank_wen     <= 1'b0;
        bank_addr    <= '0;
        bank_wdata   <= '0;
        rsp_double_q <= (width_q == DOUBLE_WIDTH);
        rsp_a_valid  <= ~wen_q && (owner_q == REQ_COMPUTE);
        rsp_b_valid  <= ~wen_q && (owner_q == REQ_EEG);
        state_q      <= ARB_IDLE;
      end
    end
  end

`ifdef INT_RES_ARB_STATS_EN
  logic stall;
  assign stall = (req_a_valid && !req_a_ready) || (req_b_valid && !req_b_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants_a     <= '0;
      stat_grants_b     <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (grant_a && stat_grants_a != '1)         stat_grants_a     <= stat_grants_a + 32'd1;
      if (grant_b && stat_grants_b != '1)         stat_grants_b     <= stat_grants_b + 32'd1;
      if (stall && stat_stall_cycles != '1)       stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
